// File: rtl/riscv_pkg.sv
// Shared branch-predictor types, default sizing and the 2-bit counter update rule.
package riscv_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_counter_e;

    localparam int BP_BHT_ENTRIES = 64;
    localparam int BP_BTB_ENTRIES = 16;
    localparam int BP_TAG_W       = 8;
    localparam int BP_GHR_W       = 6;

    // Saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic bp_counter_e counter_next(input bp_counter_e cur, input logic taken);
        bp_counter_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bp_counter_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bp_counter_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped tagged branch target buffer: combinational lookup, single write port
// that overwrites valid/tag/target on a taken update.
module branch_target_buffer
    import riscv_pkg::*;
#(
    parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int TAG_W       = BP_TAG_W,
    localparam int BTB_IDX_W  = $clog2(BTB_ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_we_i,
    output logic        hit_o,
    output logic [31:0] target_o
);

    localparam int TAG_LO = BTB_IDX_W + 2;
    localparam int TAG_HI = BTB_IDX_W + TAG_W + 1;

    logic              valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [29:0]       target_q [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [BTB_IDX_W-1:0] up_idx;
    logic [TAG_W-1:0]     up_tag;

    assign lk_idx = lookup_pc_i[BTB_IDX_W+1:2];
    assign lk_tag = lookup_pc_i[TAG_HI:TAG_LO];
    assign up_idx = upd_pc_i[BTB_IDX_W+1:2];
    assign up_tag = upd_pc_i[TAG_HI:TAG_LO];

    // PC bits above the tag and below the word offset never select or match an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[31:TAG_HI+1], lookup_pc_i[1:0],
                              upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0], upd_target_i[1:0]};

    // NOTE: the whole array sits under async reset so tags/targets are never X after reset;
    // this costs a reset net per bit, which is why memories are usually left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd_we_i) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i[31:2];
        end
    end

    assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign target_o = {target_q[lk_idx], 2'b00};

endmodule

// File: rtl/branch_predictor.sv
// Bimodal (or gshare when BP_GSHARE_EN is defined) direction predictor with a tagged BTB.
// Lookup is combinational from registered state; resolved branches train it on the clock edge.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int BHT_ENTRIES = BP_BHT_ENTRIES,
    parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int TAG_W       = BP_TAG_W,
    parameter int GHR_W       = BP_GHR_W,
    localparam int BHT_IDX_W  = $clog2(BHT_ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    bp_counter_e bht_q [BHT_ENTRIES];

    logic [BHT_IDX_W-1:0] lk_idx;
    logic [BHT_IDX_W-1:0] up_idx;
    logic                 btb_hit;
    logic [31:0]          btb_target;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // Lookup and update both hash with the current history, before this cycle's shift.
    assign lk_idx = pc_i[BHT_IDX_W+1:2]     ^ BHT_IDX_W'(ghr_q);
    assign up_idx = upd_pc_i[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);

    if (GHR_W < 2) begin : g_ghr_1
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)          ghr_q <= '0;
            else if (upd_valid_i) ghr_q <= upd_taken_i;
        end
    end else begin : g_ghr_n
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)          ghr_q <= '0;
            else if (upd_valid_i) ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_i};
        end
    end
`else
    localparam int unused_ghr_w = GHR_W;

    assign lk_idx = pc_i[BHT_IDX_W+1:2];
    assign up_idx = upd_pc_i[BHT_IDX_W+1:2];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
        end else if (upd_valid_i) begin
            bht_q[up_idx] <= counter_next(bht_q[up_idx], upd_taken_i);
        end
    end

    branch_target_buffer #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_W       (TAG_W)
    ) u_btb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_pc_i  (pc_i),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i),
        .upd_we_i     (upd_valid_i && upd_taken_i),
        .hit_o        (btb_hit),
        .target_o     (btb_target)
    );

    logic [1:0] lk_cnt;
    assign lk_cnt = bht_q[lk_idx];

    // Gating on rst_ni keeps the fall-through prediction even before the cleared state settles.
    assign pred_taken_o  = rst_ni && btb_hit && lk_cnt[1];
    assign pred_target_o = pred_taken_o ? btb_target : pc_i + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against an array-based reference model.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_i          (pc_i),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: counters as integers 0..3, BTB as plain arrays.
    int          m_cnt [64];
    bit          m_val [16];
    int          m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ghr;

    function automatic int bht_index(input logic [31:0] pc);
        int idx;
        idx = int'((pc >> 2) % 64);
`ifdef BP_GSHARE_EN
        idx = idx ^ m_ghr;
`endif
        return idx;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = 32'h0;
        end
        m_ghr = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
        int  bi;
        bit  hit;
        bi  = int'((pc >> 2) % 16);
        hit = m_val[bi] && (m_tag[bi] == int'((pc >> 6) % 256));
        taken = hit && (m_cnt[bht_index(pc)] >= 2);
        tgt   = taken ? m_tgt[bi] : pc + 32'd4;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int idx;
        int bi;
        idx = bht_index(pc);
        if (taken) begin
            if (m_cnt[idx] < 3) m_cnt[idx]++;
            bi = int'((pc >> 2) % 16);
            m_val[bi] = 1'b1;
            m_tag[bi] = int'((pc >> 6) % 256);
            m_tgt[bi] = tgt & 32'hFFFF_FFFC;
        end else if (m_cnt[idx] > 0) begin
            m_cnt[idx]--;
        end
        m_ghr = ((m_ghr << 1) | int'(taken)) % 64;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare the (pre-update) lookup, then let the edge train.
    task automatic step(input string tag, input logic [31:0] pc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        logic        et;
        logic [31:0] etg;
        @(negedge clk_i);
        pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
        #1;
        model_predict(pc, et, etg);
        check({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, et});
        check({tag, "_target"}, pred_target_o, etg);
        @(posedge clk_i);
        if (uv) model_update(upc, ut, utgt);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        step(tag, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 5)) << 2)
           | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) pc = $urandom;
        return pc;
    endfunction

    initial begin
        rst_ni = 1'b0;
        pc_i = 32'h10; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        model_reset();
        #3;
        check("rst_taken", {31'd0, pred_taken_o}, 32'd0);
        check("rst_target", pred_target_o, 32'h14);
        #20;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state for a few PCs, including the wrapping pc+4.
        lookup("init_10", 32'h10);
        lookup("init_wrap", 32'hFFFF_FFFC);
        check("wrap_const", pred_target_o, 32'h0);
        lookup("init_rand", 32'h1234_5678);

        // First taken training: same-cycle lookup still sees the old state.
        step("train1_same", 32'h10, 1'b1, 32'h10, 1'b1, 32'h200);
        check("same_cycle_const", pred_target_o, 32'h14);
`ifndef BP_GSHARE_EN
        lookup("train1_after", 32'h10);
        check("train1_const", pred_target_o, 32'h200);

        // Saturate up, then walk down past the threshold and into the floor.
        for (int i = 0; i < 3; i++) step("sat_up", 32'h10, 1'b1, 32'h10, 1'b1, 32'h203);
        step("nt1", 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
        lookup("st_minus1", 32'h10);
        check("st_minus1_const", {31'd0, pred_taken_o}, 32'd1);
        step("nt2", 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
        lookup("wnt", 32'h10);
        check("wnt_const", pred_target_o, 32'h14);
        for (int i = 0; i < 4; i++) step("floor", 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
        step("t_from_snt", 32'h10, 1'b1, 32'h10, 1'b1, 32'h200);
        lookup("snt_plus1", 32'h10);
        check("snt_plus1_const", {31'd0, pred_taken_o}, 32'd0);

        // Alias at the same BTB index with a different tag.
        step("pre_alias", 32'h10, 1'b1, 32'h10, 1'b1, 32'h200);
        step("alias_upd", 32'h10, 1'b1, 32'h110, 1'b1, 32'h300);
        lookup("alias_old", 32'h10);
        check("alias_old_const", {31'd0, pred_taken_o}, 32'd0);
        lookup("alias_new", 32'h110);
        check("alias_new_const", pred_target_o, 32'h300);
`else
        lookup("g_after", 32'h10);
        check("g_lookup_ghr1", {31'd0, pred_taken_o}, 32'd0);
        step("g_train5", 32'h14, 1'b1, 32'h10, 1'b1, 32'h200);
        step("g_nt", 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        lookup("g_ghr2", 32'h10);
`endif

        // Asynchronous reset between edges while an update is presented.
        @(negedge clk_i);
        pc_i = 32'h110; upd_valid_i = 1'b1; upd_pc_i = 32'h110; upd_taken_i = 1'b1;
        upd_target_i = 32'h400;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_taken", {31'd0, pred_taken_o}, 32'd0);
        check("async_rst_target", pred_target_o, 32'h114);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        upd_valid_i = 1'b0;
        lookup("post_rst_110", 32'h110);
        lookup("post_rst_10", 32'h10);
        for (int i = 0; i < 16; i++) lookup("post_rst_scan", 32'(i) << 2);

        // Randomized training against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] lpc;
            logic [31:0] upc;
            lpc = ($urandom_range(0, 1) == 0) ? rand_pc() : upd_pc_i;
            upc = rand_pc();
            step("rand", lpc, ($urandom_range(0, 9) < 7), upc, $urandom_range(0, 1) == 1,
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
